// File: rtl/dx_pipe_latch_pkg.sv
// Shared pipeline-boundary definitions: default widths, NOP encoding and the
// per-edge control decode used by every stage latch.
package dx_pipe_latch_pkg;

    localparam int DX_DATA_W  = 32;
    localparam int DX_NUM_OPS = 2;
    localparam int DX_INSN_W  = 32;
    localparam int DX_PC_W    = 32;
    localparam int DX_CNT_W   = 16;

    localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        HOLD   = 2'd1,
        SQUASH = 2'd2
    } pipe_ctrl_e;

endpackage

// File: rtl/dx_pipe_latch_pipe_reg.sv
// W-bit flop bank with synchronous reset, load enable and synchronous clear.
// Clear beats enable so a squash can never be masked by a concurrent load.
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] clrVal,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (clr) begin
            q <= clrVal;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dx_pipe_latch.sv
// Decode->execute pipeline latch with stall, flush, valid tracking and a
// saturating count of bubbles handed to execute.
module dx_pipe_latch
    import dx_pipe_latch_pkg::*;
#(
    parameter int                DATA_W   = DX_DATA_W,
    parameter int                NUM_OPS  = DX_NUM_OPS,
    parameter int                INSN_W   = DX_INSN_W,
    parameter int                PC_W     = DX_PC_W,
    parameter logic [INSN_W-1:0] NOP_INSN = INSN_W'(NOP_INSN_DEF),
    parameter int                CNT_W    = DX_CNT_W
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [INSN_W-1:0]         in_insn,
    input  logic [PC_W-1:0]           in_pc,
    output logic                      out_valid,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [INSN_W-1:0]         out_insn,
    output logic [PC_W-1:0]           out_pc,
    output logic [CNT_W-1:0]          bubble_count
);

    pipe_ctrl_e ctrl;
    logic       bumpCnt;
    logic       loadEn;
    logic       squash;

    // A bubble load and a flush both leave execute empty, so both count.
    always_comb begin
        ctrl    = LOAD;
        bumpCnt = 1'b0;
        if (reset) begin
            ctrl = SQUASH;
        end else if (flush) begin
            ctrl    = SQUASH;
            bumpCnt = 1'b1;
        end else if (stall) begin
            ctrl = HOLD;
        end else if (!in_valid) begin
            ctrl    = SQUASH;
            bumpCnt = 1'b1;
        end
    end

    assign loadEn = (ctrl == LOAD);
    assign squash = (ctrl == SQUASH);

    for (genvar k = 0; k < NUM_OPS; k++) begin : g_ops
        pipe_reg #(.W(DATA_W), .RST_VAL({DATA_W{1'b0}})) u_op (
            .clock (clock),
            .reset (reset),
            .en    (loadEn),
            .clr   (squash),
            .clrVal({DATA_W{1'b0}}),
            .d     (in_ops[k*DATA_W +: DATA_W]),
            .q     (out_ops[k*DATA_W +: DATA_W])
        );
    end

    pipe_reg #(.W(INSN_W), .RST_VAL(NOP_INSN)) u_insn (
        .clock (clock),
        .reset (reset),
        .en    (loadEn),
        .clr   (squash),
        .clrVal(NOP_INSN),
        .d     (in_insn),
        .q     (out_insn)
    );

    pipe_reg #(.W(PC_W), .RST_VAL({PC_W{1'b0}})) u_pc (
        .clock (clock),
        .reset (reset),
        .en    (loadEn),
        .clr   (squash),
        .clrVal({PC_W{1'b0}}),
        .d     (in_pc),
        .q     (out_pc)
    );

    pipe_reg #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clock (clock),
        .reset (reset),
        .en    (loadEn),
        .clr   (squash),
        .clrVal(1'b0),
        .d     (1'b1),
        .q     (out_valid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (bumpCnt && (bubble_count != {CNT_W{1'b1}})) begin
            bubble_count <= bubble_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_dx_pipe_latch.sv
// Scoreboard bench for dx_pipe_latch: a wide-counter instance with a non-zero
// NOP and a 3-bit-counter instance share stimulus against a rule-level model.
module tb_dx_pipe_latch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        valid;
        logic [63:0] ops;
        logic [31:0] insn;
        logic [31:0] pc;
        int          cnt;
        int          cntSat;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic [63:0] inOps = '0;
    logic [31:0] inInsn = '0;
    logic [31:0] inPc = '0;

    logic        outValid, satValid;
    logic [63:0] outOps, satOps;
    logic [31:0] outInsn, satInsn, outPc, satPc;
    logic [15:0] bubbleCount;
    logic [2:0]  satCount;

    exp_t sb[$];
    exp_t mdl;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    dx_pipe_latch #(.NOP_INSN(NOP)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(inValid), .in_ops(inOps), .in_insn(inInsn), .in_pc(inPc),
        .out_valid(outValid), .out_ops(outOps), .out_insn(outInsn),
        .out_pc(outPc), .bubble_count(bubbleCount)
    );

    dx_pipe_latch #(.CNT_W(3)) dutSat (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(inValid), .in_ops(inOps), .in_insn(inInsn), .in_pc(inPc),
        .out_valid(satValid), .out_ops(satOps), .out_insn(satInsn),
        .out_pc(satPc), .bubble_count(satCount)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Model the latch as "execute holds an instruction or it holds nothing".
    task automatic emptyStage();
        mdl.valid  = 1'b0;
        mdl.ops    = '0;
        mdl.insn   = NOP;
        mdl.pc     = '0;
        mdl.cnt    = (mdl.cnt < 65535) ? mdl.cnt + 1 : mdl.cnt;
        mdl.cntSat = (mdl.cntSat < 7) ? mdl.cntSat + 1 : mdl.cntSat;
    endtask

    task automatic step(input logic r, input logic s, input logic f, input logic v,
                        input logic [63:0] ops, input logic [31:0] insn, input logic [31:0] pc);
        reset = r; stall = s; flush = f; inValid = v;
        inOps = ops; inInsn = insn; inPc = pc;
        if (r) begin
            mdl = '{valid: 1'b0, ops: '0, insn: NOP, pc: '0, cnt: 0, cntSat: 0};
        end else if (f || (!s && !v)) begin
            emptyStage();
        end else if (!s) begin
            mdl.valid = 1'b1;
            mdl.ops   = ops;
            mdl.insn  = insn;
            mdl.pc    = pc;
        end
        @(posedge clock);
        sb.push_back(mdl);
        #1;
    endtask

    task automatic randStep(input logic r, input logic s, input logic f, input logic v);
        step(r, s, f, v, {$urandom, $urandom}, $urandom, $urandom);
    endtask

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("valid", 64'(outValid), 64'(e.valid));
            chk("ops",   outOps, e.ops);
            chk("insn",  64'(outInsn), 64'(e.insn));
            chk("pc",    64'(outPc), 64'(e.pc));
            chk("count", 64'(bubbleCount), 64'(e.cnt));
            chk("sat_valid", 64'(satValid), 64'(e.valid));
            chk("sat_ops",   satOps, e.ops);
            chk("sat_insn",  64'(satInsn), 64'(e.valid ? e.insn : 32'h0));
            chk("sat_pc",    64'(satPc), 64'(e.pc));
            chk("sat_count", 64'(satCount), 64'(e.cntSat));
        end
    end

    initial begin
        mdl = '{valid: 1'b0, ops: '0, insn: NOP, pc: '0, cnt: 0, cntSat: 0};

        repeat (2) randStep(1'b1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));

        step(1'b0, 1'b0, 1'b0, 1'b1, {32'h2222_2222, 32'h1111_1111}, 32'h0041_0020, 32'h0000_0040);

        repeat (3) randStep(1'b0, 1'b1, 1'b0, $urandom_range(0, 1));
        step(1'b0, 1'b0, 1'b0, 1'b1, {32'hA5A5_0000, 32'h0000_5A5A}, 32'h1234_5678, 32'h0000_0044);

        randStep(1'b0, 1'b1, 1'b1, 1'b1);

        repeat (5) randStep(1'b0, 1'b0, 1'b0, 1'b0);

        repeat (10) randStep(1'b0, $urandom_range(0, 1), 1'b1, $urandom_range(0, 1));
        randStep(1'b1, 1'b1, 1'b1, 1'b1);
        repeat (3) randStep(1'b0, 1'b0, 1'b1, 1'b1);
        randStep(1'b0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            randStep($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
        end

        // Long bubble run drives the narrow counter into saturation and holds it there.
        repeat (12) randStep(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) randStep(1'b0, 1'b1, 1'b0, 1'b1);

        @(negedge clock);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
